// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX path (and the future RX path):
//   - parity mode encodings
//   - transmitter FSM state encoding
//   - clog2 helper usable in constant expressions
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with push/pop strobes. Pushes while full and pops while
// empty are ignored, so callers may leave the strobes unqualified.
// The head entry is presented combinationally on o_rdata.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_wdata  write strobe and data
//   i_pop            read strobe (consumes o_rdata)
//   o_rdata          head entry
//   o_full, o_empty  status
//   o_level          occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter fed through a small input FIFO.
// Frames: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Queued frames go out back-to-back with no idle gap.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | line high, waiting for the FIFO to hold a word
//   ST_START  | start bit (0)
//   ST_DATA   | data bits, LSB first, r_idx selects the bit
//   ST_PARITY | parity bit (skipped when PARITY == PAR_NONE)
//   ST_STOP   | stop bit(s), r_idx counts them
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_s_data         word to transmit
//   i_s_valid        i_s_data valid
//   o_s_ready        FIFO not full; transfer on i_s_valid & o_s_ready
//   o_tx             registered serial line, idles high
//   o_tx_busy        a frame is in progress
//   o_tx_done        one-cycle pulse during the last cycle of the stop bit(s)
//   o_fifo_level     occupied FIFO entries
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DATA_BITS-1:0]         i_s_data,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  output logic                         o_tx,
  output logic                         o_tx_busy,
  output logic                         o_tx_done,
  output logic [clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int CW = clog2(CLKS_PER_BIT);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_tx_done;

  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic                 w_tx_bit;

  assign o_s_ready = ~w_full;
  assign w_push    = i_s_valid & ~w_full;
  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign o_tx      = r_tx;
  assign o_tx_busy = (r_state != ST_IDLE);
  assign o_tx_done = r_tx_done;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (i_s_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_frame_end = 1'b0;
    w_tx_bit    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_bit = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx_bit = r_shreg[0];
        if (w_bit_end && r_idx == 4'(DATA_BITS - 1))
          w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_tx_bit = r_par;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end && r_idx == 4'(STOP_BITS - 1)) begin
          w_frame_end = 1'b1;
          // Chain straight into the next start bit when more work is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The line is registered from the current state, so it lags the FSM by one
  // cycle; tx_done is registered the same way to stay aligned with the line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx      <= w_tx_bit;
      r_tx_done <= w_frame_end;

      if (r_state == ST_IDLE || w_bit_end) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + CW'(1);

      if (w_state_nxt != r_state)
        r_idx <= '0;
      else if (w_bit_end && (r_state == ST_DATA || r_state == ST_STOP))
        r_idx <= r_idx + 4'd1;

      if (w_pop) begin
        r_shreg <= w_head;
        r_par   <= (PARITY == PAR_ODD) ? ~^w_head : ^w_head;
      end else if (r_state == ST_DATA && w_bit_end) begin
        r_shreg <= r_shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [8:0] sd   [4];
  logic       sv   [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       busy [4];
  logic       done [4];
  logic [2:0] lvl  [4];
  logic       rx_en;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};
  logic [7:0] rx_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2 -- all CLKS_PER_BIT=4, FIFO_DEPTH=4
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(sd[0][7:0]), .i_s_valid(sv[0]), .o_s_ready(rdy[0]),
    .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]), .o_fifo_level(lvl[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(sd[1][7:0]), .i_s_valid(sv[1]), .o_s_ready(rdy[1]),
    .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]), .o_fifo_level(lvl[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(sd[2][7:0]), .i_s_valid(sv[2]), .o_s_ready(rdy[2]),
    .o_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]), .o_fifo_level(lvl[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_data(sd[3][6:0]), .i_s_valid(sv[3]), .o_s_ready(rdy[3]),
    .o_tx(tx[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]), .o_fifo_level(lvl[3]));

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      busy_cnt[d] += int'(busy[d]);
      done_cnt[d] += int'(done[d]);
    end
  end

  // Line receiver on dut0 (8N1, 4 clocks/bit): samples each bit mid-period.
  logic [7:0] rx_b;
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx[0] === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx_b[i] = tx[0];
      end
      repeat (4) @(negedge clk);
      if (rx_en) rx_q.push_back(rx_b);
      @(negedge clk);
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits in transmit order (bit 0 first); returns frame length in bits.
  function automatic int mk(input logic [8:0] data, input int dbits, input int has_par,
                            input logic par, input int stops, output logic [15:0] fr);
    int k;
    fr = '1;
    k = 0;
    fr[k] = 1'b0; k++;
    for (int i = 0; i < dbits; i++) begin fr[k] = data[i]; k++; end
    if (has_par != 0) begin fr[k] = par; k++; end
    for (int i = 0; i < stops; i++) begin fr[k] = 1'b1; k++; end
    return k;
  endfunction

  // Waits (bounded) for a start bit, then checks every bit period and the
  // position of tx_done. exp_wait > 0 also checks the number of negedges waited.
  task automatic check_frame(input int d, input logic [15:0] fr, input int len,
                             input int max_wait, input int exp_wait, input string tag);
    int w;
    int done_hits;
    logic done_last;
    logic [3:0] s;
    logic [3:0] e;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx[d] !== 1'b0 && w < max_wait);
    chk(32'(tx[d]), 0, {tag, " start seen"});
    if (exp_wait > 0) chk(w, exp_wait, {tag, " start latency"});
    done_hits = 0;
    done_last = 1'b0;
    s = '0;
    for (int t = 0; t < len * 4; t++) begin
      if (t > 0) @(negedge clk);
      s = {s[2:0], tx[d]};
      if (done[d] === 1'b1) begin
        done_hits++;
        if (t == len * 4 - 1) done_last = 1'b1;
      end
      if (t % 4 == 3) begin
        e = {4{fr[t / 4]}};
        chk(32'(s), 32'(e), $sformatf("%s bit%0d", tag, t / 4));
      end
    end
    chk(done_hits, 1, {tag, " tx_done pulses in frame"});
    chk(32'(done_last), 1, {tag, " tx_done on last cycle"});
  endtask

  task automatic push1(input int d, input logic [8:0] data, input string tag);
    @(negedge clk);
    sd[d] = data;
    sv[d] = 1'b1;
    chk(32'(rdy[d]), 1, {tag, " ready before push"});
    @(posedge clk);
    #1 sv[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] fr;
    int len, b0, d0, rx_start, idx, lows, busys;
    logic r, seen_low, rose;
    logic [7:0] w [6];

    rx_en = 1'b1;
    for (int d = 0; d < 4; d++) begin sd[d] = '0; sv[d] = 1'b0; end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk(32'(tx[0]), 1, "reset tx");
    chk(32'(busy[0]), 0, "reset tx_busy");
    chk(32'(done[0]), 0, "reset tx_done");
    chk(32'(rdy[0]), 1, "reset s_ready");
    chk(32'(lvl[0]), 0, "reset fifo_level");

    // 1: 8N1 single word 0x55
    b0 = busy_cnt[0]; d0 = done_cnt[0];
    push1(0, 9'h055, "t1");
    len = mk(9'h055, 8, 0, 1'b0, 1, fr);
    check_frame(0, fr, len, 10, 3, "t1");
    repeat (5) @(negedge clk);
    chk(busy_cnt[0] - b0, 40, "t1 busy cycles");
    chk(done_cnt[0] - d0, 1, "t1 done count");

    // 2: parity, 0x07 -> even parity bit 1, odd parity bit 0
    b0 = busy_cnt[1]; d0 = done_cnt[1];
    push1(1, 9'h007, "t2e");
    len = mk(9'h007, 8, 1, 1'b1, 1, fr);
    check_frame(1, fr, len, 10, 3, "t2e");
    repeat (5) @(negedge clk);
    chk(busy_cnt[1] - b0, 44, "t2e busy cycles");
    chk(done_cnt[1] - d0, 1, "t2e done count");
    b0 = busy_cnt[2]; d0 = done_cnt[2];
    push1(2, 9'h007, "t2o");
    len = mk(9'h007, 8, 1, 1'b0, 1, fr);
    check_frame(2, fr, len, 10, 3, "t2o");
    repeat (5) @(negedge clk);
    chk(busy_cnt[2] - b0, 44, "t2o busy cycles");
    chk(done_cnt[2] - d0, 1, "t2o done count");

    // 3: back-to-back 0xA5, 0x3C, 0xFF
    b0 = busy_cnt[0]; d0 = done_cnt[0];
    @(negedge clk);
    sd[0] = 9'h0A5; sv[0] = 1'b1;
    @(posedge clk); #1 sd[0] = 9'h03C;
    @(posedge clk); #1 sd[0] = 9'h0FF;
    @(posedge clk); #1 sv[0] = 1'b0;
    chk(32'(lvl[0]), 2, "t3 level after pushes");
    len = mk(9'h0A5, 8, 0, 1'b0, 1, fr);
    check_frame(0, fr, len, 10, 1, "t3 f0");
    len = mk(9'h03C, 8, 0, 1'b0, 1, fr);
    check_frame(0, fr, len, 1, 1, "t3 f1");
    len = mk(9'h0FF, 8, 0, 1'b0, 1, fr);
    check_frame(0, fr, len, 1, 1, "t3 f2");
    repeat (5) @(negedge clk);
    chk(busy_cnt[0] - b0, 120, "t3 busy cycles");
    chk(done_cnt[0] - d0, 3, "t3 done count");

    // 4: overflow -- six words offered with s_valid held
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx_start = rx_q.size();
    idx = 0; seen_low = 1'b0; rose = 1'b0;
    @(negedge clk);
    sd[0] = {1'b0, w[0]}; sv[0] = 1'b1;
    for (int c = 0; c < 400 && idx < 6; c++) begin
      r = rdy[0];
      if (!r && !seen_low) begin
        seen_low = 1'b1;
        chk(32'(lvl[0]), 4, "t4 level when full");
        chk(idx, 5, "t4 accepted before full");
      end
      if (r && seen_low && !rose) begin
        rose = 1'b1;
        chk(32'(done[0]), 1, "t4 ready returns with tx_done");
      end
      @(posedge clk);
      if (r) idx++;
      #1;
      if (idx < 6) sd[0] = {1'b0, w[idx]};
      else         sv[0] = 1'b0;
      @(negedge clk);
    end
    sv[0] = 1'b0;
    chk(idx, 6, "t4 words accepted");
    chk(32'(rose), 1, "t4 ready recovered");
    for (int c = 0; c < 600 && rx_q.size() < rx_start + 6; c++) @(negedge clk);
    repeat (100) @(negedge clk);
    chk(rx_q.size() - rx_start, 6, "t4 frames received");
    for (int i = 0; i < 6; i++)
      chk(32'(rx_q[rx_start + i]), 32'(w[i]), $sformatf("t4 word%0d", i));

    // 5: 7 data bits, 2 stop bits, 0x7F
    b0 = busy_cnt[3]; d0 = done_cnt[3];
    push1(3, 9'h07F, "t5");
    len = mk(9'h07F, 7, 0, 1'b0, 2, fr);
    check_frame(3, fr, len, 10, 3, "t5");
    repeat (5) @(negedge clk);
    chk(busy_cnt[3] - b0, 40, "t5 busy cycles");
    chk(done_cnt[3] - d0, 1, "t5 done count");

    // 6: reset during DATA with two words queued
    rx_en = 1'b0;
    @(negedge clk);
    sd[0] = 9'h000; sv[0] = 1'b1;
    @(posedge clk); #1 sd[0] = 9'h05A;
    @(posedge clk); #1 sd[0] = 9'h0C3;
    @(posedge clk); #1 sv[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk(32'(busy[0]), 1, "t6 busy before reset");
    chk(32'(lvl[0]), 2, "t6 level before reset");
    chk(32'(tx[0]), 0, "t6 tx low in data");
    rst_n = 1'b0;
    #1;
    chk(32'(tx[0]), 1, "t6 tx forced high");
    chk(32'(lvl[0]), 0, "t6 level cleared");
    chk(32'(rdy[0]), 1, "t6 ready after reset");
    chk(32'(busy[0]), 0, "t6 busy cleared");
    @(negedge clk) rst_n = 1'b1;
    lows = 0; busys = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) lows++;
      if (busy[0] !== 1'b0) busys++;
    end
    chk(lows, 0, "t6 line idle after release");
    chk(busys, 0, "t6 no frame after release");
    push1(0, 9'h096, "t6 new");
    len = mk(9'h096, 8, 0, 1'b0, 1, fr);
    check_frame(0, fr, len, 10, 3, "t6 new");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
